gf180mcu_icg_ctrl: RTL and testbench
====================================

Name: gf180mcu_icg_ctrl

Overview:
- Clock-gating controller sequencing the enable (E) inputs of N negative-edge integrated clock-gate cells, one per gated clock domain.
- Per domain: turns the gate on when the domain is busy or forced on, holds it on for a programmable idle hysteresis, then gates it off.
- Round-robin arbitration allows at most one domain per cycle to begin waking, limiting simultaneous clock-tree inrush.
- Sits between domain activity sources and the ICG array. TE passes through to the ICG TE pins for scan.

Parameters:
- N_DOM, 4, number of gated domains (2..16).
- IDLE_CYC, 8, idle cycles before gate-off (1..255).
- WAKE_CYC, 2, cycles E is held before RDY asserts (1..255).

Ports:
- CLK  input  1  controller clock, free-running (ungated), rising-edge.
- RST  input  1  asynchronous active-high reset.
- TE  input  1  scan/test enable; forces all gates open.
- BUSY  input  N_DOM  per-domain activity request.
- FORCE_ON  input  N_DOM  per-domain software override; keeps the gate open.
- E  output  N_DOM  to ICG E pins; registered state decode, OR'd with TE.
- RDY  output  N_DOM  gated clock stable; registered.

Behaviour:
- Reset: every domain in OFF; E=0, RDY=0; all counters 0; RR pointer=0. Reset can assert at any time and wins over all other inputs.
- Per-domain FSM states: OFF, WAKE, ON, IDLE. Each domain has a down-counter sized to max(IDLE_CYC, WAKE_CYC).
- Per-domain request: req[i] = BUSY[i] | FORCE_ON[i].
- OFF: E=0, RDY=0.
  - If req[i]=1 and domain i holds the arbitration grant this cycle: go to WAKE, load cnt=WAKE_CYC.
  - Non-granted requesters stay OFF and retry the next cycle.
- WAKE: E=1, RDY=0. Decrement cnt each edge; go to ON on the edge where cnt==1. The state does not abort if req drops during WAKE.
- ON: E=1, RDY=1. If req[i]=0, go to IDLE and load cnt=IDLE_CYC.
- IDLE: E=1, RDY=1.
  - If req[i]=1: return to ON.
  - Otherwise decrement cnt; go to OFF on the edge where cnt==1, which drops E and RDY after that edge.
- Latency:
  - req sampled high in OFF at edge k (granted): E=1 after edge k, RDY=1 after edge k+WAKE_CYC.
  - req sampled low in ON at edge m (no re-request): E=0 after edge m+IDLE_CYC.
- Arbitration:
  - Eligible set = domains in OFF with req=1.
  - Grant goes to the first eligible index at or above the RR pointer, wrapping modulo N_DOM.
  - On a grant to domain g, the pointer becomes (g+1) mod N_DOM. With no grant, the pointer holds.
  - Domains in WAKE, ON or IDLE do not participate.
- TE=1:
  - E forced to all-ones combinationally.
  - FSMs, counters and pointer freeze (no state change).
  - RDY keeps its registered value.
  - When TE returns to 0, operation resumes from the frozen state.
- All state is updated on CLK rising edge only. No combinational path from BUSY/FORCE_ON to E or RDY.

Optional Feature:
- Macro: GF180MCU_ICG_CTRL_STATS_EN.
- Defined: adds output port GATED_CYC [15:0]. It counts CLK cycles in which every domain is OFF and TE=0. The count saturates at 16'hFFFF and is cleared by RST.
- Undefined: the port and the counter are absent. Core behaviour is identical.

Test Plan:
- Reset: assert RST mid-WAKE on domain 1 -> E=4'b0000 and RDY=4'b0000 immediately (async); pointer=0 after release.
- Single wake/idle, defaults: BUSY[0] rises, sampled at edge 10.
  - E[0]=1 after edge 10 and RDY[0]=1 after edge 12.
  - BUSY[0] drops, sampled at edge 20 -> E[0]=0 and RDY[0]=0 after edge 28.
- Arbitration: BUSY=4'b1111 from reset, pointer=0 -> E rises one domain per edge in order 0,1,2,3; pointer ends at 0.
- Hysteresis: domain 2 in IDLE with cnt=3 when BUSY[2] re-asserts -> returns to ON; E[2] stays 1 with no glitch; the full IDLE_CYC applies on the next drop.
- Scan: TE=1 while all domains OFF -> E=4'b1111 immediately; state stays frozen for 50 cycles; TE=0 -> E=4'b0000, no RDY pulse.
- Stats, with macro defined: all domains OFF for 70000 cycles -> GATED_CYC=16'hFFFF, held at saturation.

Source files
------------

// File: rtl/gf180mcu_icg_ctrl.sv
// gf180mcu_icg_ctrl: sequences ICG enables per domain with wake/idle hysteresis and round-robin wake arbitration.
// Optional GATED_CYC statistics counter when GF180MCU_ICG_CTRL_STATS_EN is defined.
module gf180mcu_icg_ctrl #(
    parameter int N_DOM    = 4,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TE,
    input  logic [N_DOM-1:0] BUSY,
    input  logic [N_DOM-1:0] FORCE_ON,
    output logic [N_DOM-1:0] E,
    output logic [N_DOM-1:0] RDY
`ifdef GF180MCU_ICG_CTRL_STATS_EN
    ,
    output logic [15:0]      GATED_CYC
`endif
);
    localparam int CMAX = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_IDLE} st_t;

    st_t              r_st     [N_DOM];
    st_t              w_st_nx  [N_DOM];
    logic [CW-1:0]    r_cnt    [N_DOM];
    logic [CW-1:0]    w_cnt_nx [N_DOM];
    logic [PW-1:0]    r_ptr, w_ptr_nx;
    logic [N_DOM-1:0] r_e, r_rdy, w_req, w_elig, w_gnt;
    logic             w_found;
    int               w_idx;

    assign w_req = BUSY | FORCE_ON;
    assign E     = r_e | {N_DOM{TE}};
    assign RDY   = r_rdy;

    always_comb begin
        w_ptr_nx = r_ptr;
        w_gnt    = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < N_DOM; i++) w_elig[i] = (r_st[i] == S_OFF) && w_req[i];
        // first eligible domain at or above the pointer wins, wrapping around
        for (int k = 0; k < N_DOM; k++) begin
            w_idx = (int'(r_ptr) + k) % N_DOM;
            if (!w_found && w_elig[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_ptr_nx     = PW'((w_idx + 1) % N_DOM);
            end
        end
        for (int i = 0; i < N_DOM; i++) begin
            w_st_nx[i]  = r_st[i];
            w_cnt_nx[i] = r_cnt[i];
            case (r_st[i])
                S_OFF: if (w_gnt[i]) begin
                    w_st_nx[i]  = S_WAKE;
                    w_cnt_nx[i] = CW'(WAKE_CYC);
                end
                S_WAKE: begin
                    w_cnt_nx[i] = r_cnt[i] - CW'(1);
                    if (r_cnt[i] == CW'(1)) w_st_nx[i] = S_ON;
                end
                S_ON: if (!w_req[i]) begin
                    w_st_nx[i]  = S_IDLE;
                    w_cnt_nx[i] = CW'(IDLE_CYC);
                end
                default: if (w_req[i]) w_st_nx[i] = S_ON;
                else begin
                    w_cnt_nx[i] = r_cnt[i] - CW'(1);
                    if (r_cnt[i] == CW'(1)) w_st_nx[i] = S_OFF;
                end
            endcase
        end
    end

    // TE freezes every piece of state; E is opened combinationally above
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= '0;
            r_e   <= '0;
            r_rdy <= '0;
            for (int i = 0; i < N_DOM; i++) begin
                r_st[i]  <= S_OFF;
                r_cnt[i] <= '0;
            end
        end else if (!TE) begin
            r_ptr <= w_ptr_nx;
            for (int i = 0; i < N_DOM; i++) begin
                r_st[i]  <= w_st_nx[i];
                r_cnt[i] <= w_cnt_nx[i];
                r_e[i]   <= w_st_nx[i] != S_OFF;
                r_rdy[i] <= (w_st_nx[i] == S_ON) || (w_st_nx[i] == S_IDLE);
            end
        end
    end

`ifdef GF180MCU_ICG_CTRL_STATS_EN
    logic [15:0] r_gated;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_gated <= '0;
        else if (!TE && r_e == '0 && r_gated != 16'hFFFF) r_gated <= r_gated + 16'd1;
    end
    assign GATED_CYC = r_gated;
`endif
endmodule

// File: tb/tb_gf180mcu_icg_ctrl.sv
// tb_gf180mcu_icg_ctrl: directed vector table plus hand sequences for reset, arbitration, hysteresis and scan.
module tb_gf180mcu_icg_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TE = 1'b0;
    logic [3:0] BUSY = '0;
    logic [3:0] FORCE_ON = '0;
    logic [3:0] E, RDY;
`ifdef GF180MCU_ICG_CTRL_STATS_EN
    logic [15:0] GATED_CYC;
`endif

    gf180mcu_icg_ctrl #(.N_DOM(4), .IDLE_CYC(8), .WAKE_CYC(2)) dut (
        .CLK(CLK), .RST(RST), .TE(TE), .BUSY(BUSY), .FORCE_ON(FORCE_ON),
        .E(E), .RDY(RDY)
`ifdef GF180MCU_ICG_CTRL_STATS_EN
        , .GATED_CYC(GATED_CYC)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] busy;
        logic [3:0] force_on;
        logic       te;
        logic [3:0] e;
        logic [3:0] rdy;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; TE = 1'b0; BUSY = '0; FORCE_ON = '0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        // Each record: inputs driven before an edge, outputs expected after it.
        tv.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000});
        tv.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000});
        tv.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001});
        for (int i = 0; i < 8; i++) tv.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001});
        tv.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b0110, 4'b0000});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b1110, 4'b0010});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0110});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1110});
        tv.push_back('{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111});
        tv.push_back('{4'b0000, 4'b0100, 1'b0, 4'b1111, 4'b1111});
        tv.push_back('{4'b0000, 4'b0100, 1'b1, 4'b1111, 4'b1111});
        for (int i = 0; i < 7; i++) tv.push_back('{4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111});
        tv.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0100});
        tv.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000});

        #1;
        chk("reset_E", E, 4'b0000);
        chk("reset_RDY", RDY, 4'b0000);
        @(negedge CLK);
        RST = 1'b0;

        // arbitration from reset: one wake per edge in order 0..3
        BUSY = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            chk($sformatf("arb_E_%0d", j), E, 32'((4'b0001 << (j + 1)) - 1));
        end
        chk("arb_RDY", RDY, 4'b0011);
        BUSY = '0;
        repeat (20) @(negedge CLK);
        chk("arb_all_off", E, 4'b0000);
        BUSY = 4'b1001;
        @(negedge CLK);
        chk("arb_ptr_wrap_first", E, 4'b0001);
        @(negedge CLK);
        chk("arb_ptr_wrap_second", E, 4'b1001);

        // async reset mid-WAKE on domain 1, then pointer back to 0
        do_reset();
        BUSY = 4'b0010;
        @(negedge CLK);
        chk("wake1_E", E, 4'b0010);
        chk("wake1_RDY", RDY, 4'b0000);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_E", E, 4'b0000);
        chk("async_rst_RDY", RDY, 4'b0000);
        @(negedge CLK);
        RST = 1'b0;
        BUSY = 4'b1010;
        @(negedge CLK);
        chk("rst_ptr0", E, 4'b0010);

        // vector table
        do_reset();
        foreach (tv[i]) begin
            BUSY = tv[i].busy; FORCE_ON = tv[i].force_on; TE = tv[i].te;
            @(negedge CLK);
            chk($sformatf("vec%0d_E", i), E, tv[i].e);
            chk($sformatf("vec%0d_RDY", i), RDY, tv[i].rdy);
        end
        TE = 1'b0; BUSY = '0; FORCE_ON = '0;

        // hysteresis: re-request on domain 2 while IDLE with cnt=3
        do_reset();
        BUSY = 4'b0100;
        repeat (3) @(negedge CLK);
        chk("hyst_on_RDY", RDY, 4'b0100);
        BUSY = 4'b0000;
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            chk($sformatf("hyst_idle_E_%0d", j), E, 4'b0100);
        end
        BUSY = 4'b0100;
        @(negedge CLK);
        chk("hyst_back_on_E", E, 4'b0100);
        chk("hyst_back_on_RDY", RDY, 4'b0100);
        @(negedge CLK);
        BUSY = 4'b0000;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            chk($sformatf("hyst_full_idle_E_%0d", j), E, 4'b0100);
        end
        @(negedge CLK);
        chk("hyst_off_E", E, 4'b0000);
        chk("hyst_off_RDY", RDY, 4'b0000);

        // scan: all OFF, TE with a pending request must not wake anything
        TE = 1'b1; BUSY = 4'b0001;
        #1;
        chk("scan_E_immediate", E, 4'b1111);
        for (int j = 0; j < 50; j++) begin
            @(negedge CLK);
            chk($sformatf("scan_frozen_E_%0d", j), E, 4'b1111);
            chk($sformatf("scan_frozen_RDY_%0d", j), RDY, 4'b0000);
        end
        TE = 1'b0; BUSY = 4'b0000;
        #1;
        chk("scan_release_E", E, 4'b0000);
        @(negedge CLK);
        chk("scan_after_E", E, 4'b0000);
        chk("scan_after_RDY", RDY, 4'b0000);

`ifdef GF180MCU_ICG_CTRL_STATS_EN
        do_reset();
        repeat (70000) @(negedge CLK);
        chk("stats_sat", GATED_CYC, 16'hFFFF);
        repeat (10) @(negedge CLK);
        chk("stats_hold", GATED_CYC, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
